// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNTW  = 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    // Quotient returned for a zero divisor.
    localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] prem_i,
    input  logic             dbit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] prem_o,
    output logic             qbit_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {prem_i, dbit_i};
    // Two guard bits so the borrow is unambiguous even when the shifted remainder exceeds 2^WIDTH.
    assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
    assign qbit_o  = ~trial[WIDTH+1];
    assign prem_o  = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle, with stall and rdy.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] num1_i,
    input  logic [WIDTH-1:0] num2_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             rdy_o,
    output logic             work_o,
    output logic             dbz_o
);

    div_state_e       state_q;
    logic [CNTW-1:0]  cnt_q;
    logic [WIDTH-1:0] dvd_q, dvs_q, prem_q;
    logic             qneg_q, rneg_q, div0_q;
    logic [WIDTH-1:0] result_q, remainder_q;
    logic             rdy_q, work_q, dbz_q;

    logic [WIDTH-1:0] prem_d;
    logic             qbit_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem_i    (prem_q),
        .dbit_i    (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .prem_o    (prem_d),
        .qbit_o    (qbit_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            div0_q      <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            rdy_q       <= 1'b0;
            work_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        div0_q  <= (num2_i == '0);
                        // A zero divisor keeps the raw dividend so it can be returned unmodified.
                        dvd_q   <= (num2_i == '0) ? num1_i : mag(num1_i, mode_i);
                        dvs_q   <= mag(num2_i, mode_i);
                        qneg_q  <= mode_i & (num1_i[WIDTH-1] ^ num2_i[WIDTH-1]);
                        rneg_q  <= mode_i & num1_i[WIDTH-1];
                        prem_q  <= '0;
                        cnt_q   <= '0;
                        work_q  <= 1'b1;
                        state_q <= (num2_i == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    dvd_q  <= {dvd_q[WIDTH-2:0], qbit_d};
                    cnt_q  <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(WIDTH-1)) state_q <= FIX;
                end
                FIX: begin
                    if (div0_q) begin
                        result_q    <= WIDTH'($signed(DIV0_QUOT));
                        remainder_q <= dvd_q;
                        dbz_q       <= 1'b1;
                    end else begin
                        result_q    <= qneg_q ? -dvd_q : dvd_q;
                        remainder_q <= rneg_q ? -prem_q : prem_q;
                        dbz_q       <= 1'b0;
                    end
                    work_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o    = result_q;
    assign remainder_o = remainder_q;
    assign rdy_o       = rdy_q;
    assign work_o      = work_q;
    assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus random checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode;
    logic [15:0] num1, num2;
    logic [15:0] result, remainder;
    logic        rdy, work, dbz;

    int total = 0;
    int bad   = 0;

    seq_divider dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .mode_i      (mode),
        .num1_i      (num1),
        .num2_i      (num2),
        .result_o    (result),
        .remainder_o (remainder),
        .rdy_o       (rdy),
        .work_o      (work),
        .dbz_o       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating signed division with remainder taking the dividend's sign.
    function automatic void model(input logic m, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r, output logic z);
        int sa, sb;
        if (b == 16'd0) begin
            q = 16'hFFFF; r = a; z = 1'b1;
        end else if (m) begin
            sa = $signed(a); sb = $signed(b);
            q = 16'(sa / sb); r = 16'(sa % sb); z = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Entered #1 after an edge with the DUT idle.
    task automatic do_op(input string tag, input logic m, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er;
        logic        ez;
        int          lat, wk;
        bit          got;
        model(m, a, b, eq, er, ez);
        mode = m; num1 = a; num2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; wk = 0; got = 0;
        if (work) wk++;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            if (rdy) begin got = 1; lat = i; end
            else if (work) wk++;
        end
        chk({tag, "_seen_rdy"}, got, 1);
        chk({tag, "_latency"}, lat, (b == 0) ? 2 : 18);
        chk({tag, "_work_cycles"}, wk, (b == 0) ? 1 : 17);
        chk({tag, "_result"}, result, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_dbz"}, dbz, ez);
        @(posedge clk); #1;
        chk({tag, "_rdy_pulse"}, rdy, 0);
    endtask

    initial begin
        int          nrdy;
        logic [15:0] cap_q, cap_r;
        logic        m;
        logic [15:0] a, b;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; num1 = '0; num2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_work", work, 0);
        chk("rst_dbz", dbz, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("u100_7", 1'b0, 16'd100, 16'd7);
        do_op("s_m7_2", 1'b1, 16'hFFF9, 16'd2);
        do_op("s_7_m2", 1'b1, 16'd7, 16'hFFFE);
        do_op("s_ovf", 1'b1, 16'h8000, 16'hFFFF);
        do_op("u_max_1", 1'b0, 16'hFFFF, 16'd1);
        do_op("div0", 1'b0, 16'd1234, 16'd0);
        do_op("after_div0", 1'b0, 16'd10, 16'd3);
        do_op("s_div0", 1'b1, 16'h8001, 16'd0);

        // Second start mid-operation must be ignored.
        mode = 1'b0; num1 = 16'd100; num2 = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        num1 = 16'd9; num2 = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nrdy = 0; cap_q = '0; cap_r = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rdy) begin nrdy++; cap_q = result; cap_r = remainder; end
        end
        chk("ign_rdy_count", nrdy, 1);
        chk("ign_result", cap_q, 16'd14);
        chk("ign_remainder", cap_r, 16'd2);

        // Reset mid-operation discards it.
        num1 = 16'd1000; num2 = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_remainder", remainder, 0);
        chk("mid_rst_work", work, 0);
        chk("mid_rst_dbz", dbz, 0);
        chk("mid_rst_rdy", rdy, 0);
        rst_n = 1'b1;
        nrdy = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rdy) nrdy++;
        end
        chk("mid_rst_no_rdy", nrdy, 0);
        do_op("post_rst_50_5", 1'b0, 16'd50, 16'd5);

        for (int k = 0; k < 30; k++) begin
            m = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 20));
                3:       b = m ? 16'(-$urandom_range(1, 20)) : 16'($urandom);
                default: b = 16'($urandom);
            endcase
            do_op("rand", m, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
